// File: rtl/display_scan_mux.sv
// Time-multiplexed 7-segment driver for the egg timer: picks setting/running/zero digits by
// timer state, scans them across DIGITS common-anode digits, and applies blink and blanking.
module display_scan_mux #(
    parameter int unsigned DIGITS    = 4,
    parameter int unsigned SCAN_DIV  = 1000,
    parameter int unsigned BLINK_DIV = 250000,
    parameter int unsigned LZ_BLANK  = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [4*DIGITS-1:0]   setting_i,
    input  logic [4*DIGITS-1:0]   running_i,
    input  logic                  is_init_i,
    input  logic                  is_setting_i,
    input  logic                  is_running_i,
    input  logic                  is_done_i,
    input  logic [2:0]            cursor_i,
    output logic [6:0]            seg_o,
    output logic [DIGITS-1:0]     an_o
);

    localparam int unsigned IdxW   = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int unsigned ScanW  = $clog2(SCAN_DIV);
    localparam int unsigned BlinkW = $clog2(BLINK_DIV);

    localparam logic [6:0] SegDark = 7'h7F;

    logic [ScanW-1:0]  scan_q, scan_d;
    logic [BlinkW-1:0] blink_q, blink_d;
    logic [IdxW-1:0]   idx_q, idx_d;
    logic              phase_q, phase_d;
    logic [6:0]        seg_q, seg_d;
    logic [DIGITS-1:0] an_q, an_d;

    logic              scan_wrap;
    logic              blink_wrap;
    logic              sel_set;
    logic              sel_run;
    logic [4*DIGITS-1:0] src;
    logic [3:0]        digit;
    logic              upper_nonzero;
    logic              cursor_hit;
    logic              blank_cursor;
    logic              blank_done;
    logic              blank_lz;
    logic [6:0]        seg_code;

    // Init state and "no flag" both select the zero source, so the init flag needs no logic.
    logic unused_is_init;
    assign unused_is_init = is_init_i;

    function automatic logic [6:0] seg_decode(input logic [3:0] value);
        logic [6:0] code;
        case (value)
            4'd0:    code = 7'h40;
            4'd1:    code = 7'h79;
            4'd2:    code = 7'h24;
            4'd3:    code = 7'h30;
            4'd4:    code = 7'h19;
            4'd5:    code = 7'h12;
            4'd6:    code = 7'h02;
            4'd7:    code = 7'h78;
            4'd8:    code = 7'h00;
            4'd9:    code = 7'h10;
            default: code = SegDark;
        endcase
        return code;
    endfunction

    // Free-running scan and blink timebases.
    always_comb begin
        scan_wrap  = (scan_q == ScanW'(SCAN_DIV - 1));
        blink_wrap = (blink_q == BlinkW'(BLINK_DIV - 1));

        scan_d  = scan_wrap ? '0 : scan_q + ScanW'(1);
        blink_d = blink_wrap ? '0 : blink_q + BlinkW'(1);
        phase_d = blink_wrap ? ~phase_q : phase_q;

        idx_d = idx_q;
        if (scan_wrap) begin
            idx_d = (idx_q == IdxW'(DIGITS - 1)) ? '0 : idx_q + IdxW'(1);
        end
    end

    always_comb begin
        sel_set = is_setting_i;
        sel_run = ~is_setting_i & (is_running_i | is_done_i);

        src = '0;
        if (sel_set) begin
            src = setting_i;
        end else if (sel_run) begin
            src = running_i;
        end
    end

    // Current digit value and whether it or any more-significant digit is nonzero.
    always_comb begin
        digit         = 4'd0;
        upper_nonzero = 1'b0;
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (idx_q == IdxW'(i)) begin
                digit = src[4*i +: 4];
            end
            if ((i >= int'(idx_q)) && (src[4*i +: 4] != 4'd0)) begin
                upper_nonzero = 1'b1;
            end
        end
    end

    always_comb begin
        cursor_hit   = (int'(cursor_i) == int'(idx_q));
        blank_cursor = is_setting_i & cursor_hit & phase_q;
        blank_done   = is_done_i & phase_q;
        blank_lz     = (LZ_BLANK != 0) & sel_run & (idx_q != '0) & ~upper_nonzero;

        seg_code = seg_decode(digit);
        seg_d    = (blank_cursor | blank_done | blank_lz) ? SegDark : seg_code;
        an_d     = ~(DIGITS'(1) << idx_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scan_q  <= '0;
            blink_q <= '0;
            idx_q   <= '0;
            phase_q <= 1'b0;
            seg_q   <= SegDark;
            an_q    <= '1;
        end else begin
            scan_q  <= scan_d;
            blink_q <= blink_d;
            idx_q   <= idx_d;
            phase_q <= phase_d;
            seg_q   <= seg_d;
            an_q    <= an_d;
        end
    end

    assign seg_o = seg_q;
    assign an_o  = an_q;

endmodule

// File: tb/tb_display_scan_mux.sv
// Directed bench for display_scan_mux: DIGITS=4, SCAN_DIV=4, BLINK_DIV=16, with and without
// leading-zero blanking. After edge n of a run, digit (n-1)/4 mod 4 and phase (n-1)/16 mod 2.
module tb_display_scan_mux;

    logic        clk;
    logic        rst_n;
    logic [15:0] setting;
    logic [15:0] running;
    logic        is_init;
    logic        is_setting;
    logic        is_running;
    logic        is_done;
    logic [2:0]  cursor;
    logic [6:0]  seg;
    logic [3:0]  an;
    logic [6:0]  seg_nlz;
    logic [3:0]  an_nlz;

    int cyc;
    int n_cmp;
    int n_bad;

    logic [3:0] an_tab  [4] = '{4'hE, 4'hD, 4'hB, 4'h7};
    logic [6:0] run_tab [4] = '{7'h19, 7'h30, 7'h24, 7'h79};

    display_scan_mux #(
        .DIGITS    (4),
        .SCAN_DIV  (4),
        .BLINK_DIV (16),
        .LZ_BLANK  (1)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .setting_i    (setting),
        .running_i    (running),
        .is_init_i    (is_init),
        .is_setting_i (is_setting),
        .is_running_i (is_running),
        .is_done_i    (is_done),
        .cursor_i     (cursor),
        .seg_o        (seg),
        .an_o         (an)
    );

    display_scan_mux #(
        .DIGITS    (4),
        .SCAN_DIV  (4),
        .BLINK_DIV (16),
        .LZ_BLANK  (0)
    ) dut_nlz (
        .clk          (clk),
        .rst_n        (rst_n),
        .setting_i    (setting),
        .running_i    (running),
        .is_init_i    (is_init),
        .is_setting_i (is_setting),
        .is_running_i (is_running),
        .is_done_i    (is_done),
        .cursor_i     (cursor),
        .seg_o        (seg_nlz),
        .an_o         (an_nlz)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: observed no finish expected finish by 100000");
        $fatal(1, "watchdog expired");
    end

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s cyc=%0d: observed %h expected %h", tag, cyc, obs, exp);
        end
    endtask

    function automatic int dig(input int n);
        return ((n - 1) / 4) % 4;
    endfunction

    function automatic int ph(input int n);
        return ((n - 1) / 16) % 2;
    endfunction

    initial begin
        int d;
        n_cmp      = 0;
        n_bad      = 0;
        cyc        = 0;
        rst_n      = 1'b0;
        setting    = 16'h0000;
        running    = 16'h0000;
        is_init    = 1'b0;
        is_setting = 1'b0;
        is_running = 1'b0;
        is_done    = 1'b0;
        cursor     = 3'd0;

        // Reset state holds while reset is asserted across edges.
        step();
        step();
        chk("rst_seg", {1'b0, seg}, 8'h7F);
        chk("rst_an", {4'h0, an}, 8'h0F);

        // Running 1234: scan order and codes.
        is_running = 1'b1;
        running    = 16'h1234;
        @(negedge clk);
        rst_n = 1'b1;
        cyc   = 0;
        for (int n = 1; n <= 32; n++) begin
            step();
            d = dig(cyc);
            chk("run_an", {4'h0, an}, {4'h0, an_tab[d]});
            chk("run_seg", {1'b0, seg}, {1'b0, run_tab[d]});
        end

        // Setting 0500, cursor on digit 2 blinks.
        is_running = 1'b0;
        is_setting = 1'b1;
        cursor     = 3'd2;
        setting    = 16'h0500;
        for (int n = 33; n <= 64; n++) begin
            step();
            d = dig(cyc);
            if (d == 2) begin
                chk("set_blink", {1'b0, seg}, (ph(cyc) == 1) ? 8'h7F : 8'h12);
            end else begin
                chk("set_other", {1'b0, seg}, 8'h40);
            end
        end

        // Running 0007: leading zeros blanked only with LZ_BLANK=1.
        is_setting = 1'b0;
        setting    = 16'h0000;
        is_running = 1'b1;
        running    = 16'h0007;
        for (int n = 65; n <= 80; n++) begin
            step();
            d = dig(cyc);
            chk("lz_seg", {1'b0, seg}, (d == 0) ? 8'h78 : 8'h7F);
            chk("nlz_seg", {1'b0, seg_nlz}, (d == 0) ? 8'h78 : 8'h40);
        end

        // Done with running 0000: alarm blink, phase 1 first in this window.
        is_running = 1'b0;
        is_done    = 1'b1;
        running    = 16'h0000;
        for (int n = 81; n <= 112; n++) begin
            step();
            d = dig(cyc);
            if (ph(cyc) == 1) begin
                chk("done_hid", {1'b0, seg}, 8'h7F);
                chk("done_hid_nlz", {1'b0, seg_nlz}, 8'h7F);
            end else begin
                chk("done_vis", {1'b0, seg}, (d == 0) ? 8'h40 : 8'h7F);
                chk("done_vis_nlz", {1'b0, seg_nlz}, 8'h40);
            end
        end

        // Init selects zero source.
        is_done = 1'b0;
        is_init = 1'b1;
        for (int n = 113; n <= 128; n++) begin
            step();
            chk("init_seg", {1'b0, seg}, 8'h40);
            chk("init_an", {4'h0, an}, {4'h0, an_tab[dig(cyc)]});
        end

        // Setting wins over running; cursor beyond DIGITS never blinks.
        is_init    = 1'b0;
        is_setting = 1'b1;
        is_running = 1'b1;
        setting    = 16'h9999;
        running    = 16'h1234;
        cursor     = 3'd7;
        for (int n = 129; n <= 160; n++) begin
            step();
            chk("prio_seg", {1'b0, seg}, 8'h10);
        end

        // Non-BCD setting digit 2 = C shows dark.
        is_running = 1'b0;
        setting    = 16'h0C00;
        for (int n = 161; n <= 176; n++) begin
            step();
            chk("nbcd_seg", {1'b0, seg}, (dig(cyc) == 2) ? 8'h7F : 8'h40);
        end

        // Asynchronous reset mid-slot on digit 2.
        setting = 16'h9999;
        for (int n = 177; n <= 186; n++) begin
            step();
        end
        chk("pre_rst_an", {4'h0, an}, 8'h0B);
        chk("pre_rst_seg", {1'b0, seg}, 8'h10);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_seg", {1'b0, seg}, 8'h7F);
        chk("async_an", {4'h0, an}, 8'h0F);
        chk("async_an_nlz", {4'h0, an_nlz}, 8'h0F);
        step();
        chk("held_seg", {1'b0, seg}, 8'h7F);
        chk("held_an", {4'h0, an}, 8'h0F);

        // After release: digit 0 first, blink phase restarts at visible.
        cursor = 3'd0;
        @(negedge clk);
        rst_n = 1'b1;
        cyc   = 0;
        for (int n = 1; n <= 20; n++) begin
            step();
            d = dig(cyc);
            chk("rel_an", {4'h0, an}, {4'h0, an_tab[d]});
            chk("rel_seg", {1'b0, seg}, (d == 0 && ph(cyc) == 1) ? 8'h7F : 8'h10);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
